// File: rtl/commit_gpr_snapshot.sv
// Architectural commit stage: GPR file, committed PC and a difftest snapshot handshake,
// with ebreak halt and commit-starvation hang detection. Optional PC ring: IRINGBUF_EN.
module commit_gpr_snapshot #(
  parameter int XLEN    = 64,
  parameter int NR_GPR  = 32,
  parameter int TIMEOUT = 5000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmt_valid,
  output logic                   cmt_ready,
  input  logic [XLEN-1:0]        cmt_pc,
  input  logic [31:0]            cmt_inst,
  input  logic                   cmt_rd_wen,
  input  logic [4:0]             cmt_rd_addr,
  input  logic [XLEN-1:0]        cmt_rd_data,
  output logic [NR_GPR*XLEN-1:0] gpr_flat,
  output logic [XLEN-1:0]        pc_val,
  output logic                   dt_valid,
  input  logic                   dt_ready,
  output logic [63:0]            inst_cnt,
  output logic                   halt,
  output logic [XLEN-1:0]        halt_code,
  output logic                   hang
`ifdef IRINGBUF_EN
  ,
  output logic [8*XLEN-1:0]      iring_flat,
  output logic [2:0]             iring_ptr
`endif
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_HALT,
    ST_HANG
  } state_e;

  localparam int            TW      = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [31:0]   EBREAK  = 32'h0010_0073;

  state_e                       state_q, state_d;
  logic [NR_GPR-1:0][XLEN-1:0]  gpr_q, gpr_d;
  logic [XLEN-1:0]              pc_q, pc_d;
  logic                         dt_valid_q, dt_valid_d;
  logic [63:0]                  inst_cnt_q, inst_cnt_d;
  logic                         halt_q, halt_d;
  logic [XLEN-1:0]              halt_code_q, halt_code_d;
  logic                         hang_q, hang_d;
  logic [TW-1:0]                to_cnt_q, to_cnt_d;

  logic accept;
  logic backpressured;

  assign cmt_ready     = (state_q == ST_RUN) & (~dt_valid_q | dt_ready);
  assign accept        = cmt_valid & cmt_ready;
  assign backpressured = dt_valid_q & ~dt_ready;

  always_comb begin
    // NOTE: every _d takes its _q value first, so no branch can leave a latch behind.
    state_d     = state_q;
    gpr_d       = gpr_q;
    pc_d        = pc_q;
    dt_valid_d  = dt_valid_q;
    inst_cnt_d  = inst_cnt_q;
    halt_d      = halt_q;
    halt_code_d = halt_code_q;
    hang_d      = hang_q;
    to_cnt_d    = to_cnt_q;

    if (accept) begin
      if (cmt_rd_wen && (cmt_rd_addr != '0)) begin
        gpr_d[cmt_rd_addr] = cmt_rd_data;
      end
      pc_d       = cmt_pc;
      inst_cnt_d = inst_cnt_q + 64'd1;
      dt_valid_d = 1'b1;
      if (cmt_inst == EBREAK) begin
        // a0 is sampled before this edge's writeback.
        halt_code_d = gpr_q[10];
        halt_d      = 1'b1;
        state_d     = ST_HALT;
      end
    end else if (dt_ready) begin
      dt_valid_d = 1'b0;
    end

    // Waiting on the checker is not starvation, so the counter pauses under backpressure.
    if (state_q == ST_RUN) begin
      if (accept) begin
        to_cnt_d = '0;
      end else if (!backpressured) begin
        if (to_cnt_q == TO_LAST) begin
          hang_d  = 1'b1;
          state_d = ST_HANG;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments only here; all next-state math lives in always_comb.
    if (rst) begin
      state_q     <= ST_RUN;
      // NOTE: the GPR file is a flop array that must read zero after reset, so it is
      // cleared here rather than left to initialise through writes like a RAM would.
      gpr_q       <= '0;
      pc_q        <= '0;
      dt_valid_q  <= 1'b0;
      inst_cnt_q  <= '0;
      halt_q      <= 1'b0;
      halt_code_q <= '0;
      hang_q      <= 1'b0;
      to_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      gpr_q       <= gpr_d;
      pc_q        <= pc_d;
      dt_valid_q  <= dt_valid_d;
      inst_cnt_q  <= inst_cnt_d;
      halt_q      <= halt_d;
      halt_code_q <= halt_code_d;
      hang_q      <= hang_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

  assign gpr_flat  = gpr_q;
  assign pc_val    = pc_q;
  assign dt_valid  = dt_valid_q;
  assign inst_cnt  = inst_cnt_q;
  assign halt      = halt_q;
  assign halt_code = halt_code_q;
  assign hang      = hang_q;

`ifdef IRINGBUF_EN
  // Ring only advances on accept, so it freezes by itself once HALT/HANG blocks commits.
  logic [7:0][XLEN-1:0] iring_q, iring_d;
  logic [2:0]           iring_ptr_q, iring_ptr_d;

  always_comb begin
    iring_d     = iring_q;
    iring_ptr_d = iring_ptr_q;
    if (accept) begin
      iring_d[iring_ptr_q] = cmt_pc;
      iring_ptr_d          = iring_ptr_q + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iring_q     <= '0;
      iring_ptr_q <= '0;
    end else begin
      iring_q     <= iring_d;
      iring_ptr_q <= iring_ptr_d;
    end
  end

  assign iring_flat = iring_q;
  assign iring_ptr  = iring_ptr_q;
`else
  // Without the ring there is no extra state; the commit path above is complete as is.
`endif

endmodule

// File: tb/tb_commit_gpr_snapshot.sv
// Scoreboard bench for commit_gpr_snapshot: commits push expected snapshots, a negedge
// monitor pops one per dt_valid/dt_ready handshake. Ring checks run when IRINGBUF_EN is set.
module tb_commit_gpr_snapshot;

  localparam int          XLEN    = 64;
  localparam int          NR_GPR  = 32;
  localparam int          TIMEOUT = 16;
  localparam logic [31:0] EBREAK  = 32'h0010_0073;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   cmt_valid;
  logic                   cmt_ready;
  logic [XLEN-1:0]        cmt_pc;
  logic [31:0]            cmt_inst;
  logic                   cmt_rd_wen;
  logic [4:0]             cmt_rd_addr;
  logic [XLEN-1:0]        cmt_rd_data;
  logic [NR_GPR*XLEN-1:0] gpr_flat;
  logic [XLEN-1:0]        pc_val;
  logic                   dt_valid;
  logic                   dt_ready;
  logic [63:0]            inst_cnt;
  logic                   halt;
  logic [XLEN-1:0]        halt_code;
  logic                   hang;
`ifdef IRINGBUF_EN
  logic [8*XLEN-1:0]      iring_flat;
  logic [2:0]             iring_ptr;
`endif

  commit_gpr_snapshot #(.XLEN(XLEN), .NR_GPR(NR_GPR), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmt_valid  (cmt_valid),
    .cmt_ready  (cmt_ready),
    .cmt_pc     (cmt_pc),
    .cmt_inst   (cmt_inst),
    .cmt_rd_wen (cmt_rd_wen),
    .cmt_rd_addr(cmt_rd_addr),
    .cmt_rd_data(cmt_rd_data),
    .gpr_flat   (gpr_flat),
    .pc_val     (pc_val),
    .dt_valid   (dt_valid),
    .dt_ready   (dt_ready),
    .inst_cnt   (inst_cnt),
    .halt       (halt),
    .halt_code  (halt_code),
    .hang       (hang)
`ifdef IRINGBUF_EN
    ,
    .iring_flat (iring_flat),
    .iring_ptr  (iring_ptr)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0]           pc;
    logic [63:0]           cnt;
    logic [31:0][63:0]     gprs;
  } snap_t;

  snap_t             exp_q[$];
  logic [31:0][63:0] m_gpr;
  logic [63:0]       m_cnt;
  int                n_vec = 0;
  int                n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    cmt_valid = 1'b0;
    dt_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    m_gpr = '0;
    m_cnt = '0;
  endtask

  // Presents one commit; the expected snapshot is pushed in the cycle it is accepted.
  task automatic do_commit(input logic [63:0] pc, input logic [31:0] inst, input logic wen,
                           input logic [4:0] addr, input logic [63:0] data);
    snap_t s;
    bit    done = 1'b0;
    cmt_valid   = 1'b1;
    cmt_pc      = pc;
    cmt_inst    = inst;
    cmt_rd_wen  = wen;
    cmt_rd_addr = addr;
    cmt_rd_data = data;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (cmt_ready) begin
        if (wen && addr != 5'd0) m_gpr[addr] = data;
        m_cnt  = m_cnt + 64'd1;
        s.pc   = pc;
        s.cnt  = m_cnt;
        s.gprs = m_gpr;
        exp_q.push_back(s);
        done = 1'b1;
      end
    end
    if (!done) begin
      n_vec++;
      n_bad++;
      $display("FAIL commit_accept pc=0x%0h: cmt_ready stayed 0 for 40 cycles, expected 1", pc);
    end
    @(posedge clk);
    #1;
    cmt_valid = 1'b0;
  endtask

  // Monitor: each handshake consumes exactly one expected snapshot.
  always @(negedge clk) begin
    snap_t e;
    bit    bad;
    if (!rst && dt_valid && dt_ready) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL snapshot: dt_valid with pc_val=0x%0h, expected no snapshot", pc_val);
      end else begin
        e   = exp_q.pop_front();
        bad = 1'b0;
        if (pc_val !== e.pc) begin
          bad = 1'b1;
          $display("FAIL snap_pc: got 0x%0h, expected 0x%0h", pc_val, e.pc);
        end
        if (inst_cnt !== e.cnt) begin
          bad = 1'b1;
          $display("FAIL snap_cnt: got %0d, expected %0d", inst_cnt, e.cnt);
        end
        for (int r = 0; r < 32 && !bad; r++) begin
          if (gpr_flat[r*64 +: 64] !== e.gprs[r]) begin
            bad = 1'b1;
            $display("FAIL snap_x%0d: got 0x%0h, expected 0x%0h", r, gpr_flat[r*64 +: 64],
                     e.gprs[r]);
          end
        end
        if (bad) n_bad++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    cmt_valid   = 1'b0;
    cmt_pc      = '0;
    cmt_inst    = NOP;
    cmt_rd_wen  = 1'b0;
    cmt_rd_addr = '0;
    cmt_rd_data = '0;
    dt_ready    = 1'b1;
    do_reset();

    check("reset_cmt_ready", 64'(cmt_ready), 64'd1);
    check("reset_dt_valid", 64'(dt_valid), 64'd0);
    check("reset_pc_val", pc_val, 64'd0);
    check("reset_inst_cnt", inst_cnt, 64'd0);
    check("reset_halt", 64'(halt), 64'd0);
    check("reset_halt_code", halt_code, 64'd0);
    check("reset_hang", 64'(hang), 64'd0);
    check("reset_gpr_any", 64'(|gpr_flat), 64'd0);

    // Basic commits, including a dropped x0 write and a non-writing commit.
    do_commit(64'h8000_0000, 32'h02a0_0293, 1'b1, 5'd5, 64'h2a);
    check("addi_x5", gpr_flat[5*64 +: 64], 64'h2a);
    check("addi_pc", pc_val, 64'h8000_0000);
    check("addi_dt_valid", 64'(dt_valid), 64'd1);
    check("addi_cnt", inst_cnt, 64'd1);
    do_commit(64'h8000_0004, NOP, 1'b1, 5'd0, 64'hdead);
    check("x0_write_dropped", gpr_flat[0 +: 64], 64'd0);
    check("x0_cnt", inst_cnt, 64'd2);
    do_commit(64'h8000_0008, NOP, 1'b1, 5'd10, 64'h1234);
    do_commit(64'h8000_000c, NOP, 1'b1, 5'd31, 64'hffff_ffff_ffff_ffff);
    do_commit(64'h8000_0010, NOP, 1'b1, 5'd5, 64'h99);
    do_commit(64'h8000_0014, NOP, 1'b0, 5'd7, 64'h77);
    check("no_wen_x7", gpr_flat[7*64 +: 64], 64'd0);
    check("x31_max", gpr_flat[31*64 +: 64], 64'hffff_ffff_ffff_ffff);

    // Backpressure: commit held off, snapshot stable, no hang despite > TIMEOUT cycles.
    @(posedge clk);
    #1;
    check("dt_valid_drops", 64'(dt_valid), 64'd0);
    dt_ready = 1'b0;
    do_commit(64'h8000_0100, NOP, 1'b1, 5'd3, 64'h333);
    cmt_valid   = 1'b1;
    cmt_pc      = 64'h8000_0104;
    cmt_rd_wen  = 1'b1;
    cmt_rd_addr = 5'd4;
    cmt_rd_data = 64'h444;
    repeat (20) begin
      @(negedge clk);
      check("bp_cmt_ready", 64'(cmt_ready), 64'd0);
      check("bp_pc_stable", pc_val, 64'h8000_0100);
    end
    check("bp_dt_valid", 64'(dt_valid), 64'd1);
    check("bp_no_hang", 64'(hang), 64'd0);
    @(posedge clk);
    #1;
    dt_ready = 1'b1;
    do_commit(64'h8000_0104, NOP, 1'b1, 5'd4, 64'h444);
    check("b2b_dt_valid", 64'(dt_valid), 64'd1);
    check("b2b_pc", pc_val, 64'h8000_0104);

    // ebreak with a0 = 0, then commits are refused and nothing advances.
    do_commit(64'h8000_0108, 32'h0000_0513, 1'b1, 5'd10, 64'd0);
    do_commit(64'h8000_010c, EBREAK, 1'b0, 5'd0, 64'd0);
    check("ebreak_halt", 64'(halt), 64'd1);
    check("ebreak_code0", halt_code, 64'd0);
    check("ebreak_dt_valid", 64'(dt_valid), 64'd1);
    check("ebreak_cnt", inst_cnt, m_cnt);
    cmt_valid   = 1'b1;
    cmt_pc      = 64'h8000_0110;
    cmt_rd_addr = 5'd6;
    cmt_rd_data = 64'h666;
    repeat (20) @(posedge clk);
    #1;
    check("halt_cmt_ready", 64'(cmt_ready), 64'd0);
    check("halt_cnt_frozen", inst_cnt, m_cnt);
    check("halt_x6_frozen", gpr_flat[6*64 +: 64], 64'd0);
    check("halt_dt_done", 64'(dt_valid), 64'd0);
    check("halt_no_hang", 64'(hang), 64'd0);
    cmt_valid = 1'b0;

    // ebreak reports the a0 value written by an earlier commit.
    do_reset();
    do_commit(64'h8000_0000, NOP, 1'b1, 5'd10, 64'h55);
    do_commit(64'h8000_0004, EBREAK, 1'b0, 5'd0, 64'd0);
    check("ebreak_code55", halt_code, 64'h55);
    check("ebreak_halt2", 64'(halt), 64'd1);

    // Timeout: TIMEOUT idle edges hang; one edge fewer does not.
    do_reset();
    repeat (TIMEOUT - 1) @(posedge clk);
    #1;
    check("to_before_hang", 64'(hang), 64'd0);
    check("to_before_ready", 64'(cmt_ready), 64'd1);
    @(posedge clk);
    #1;
    check("to_hang", 64'(hang), 64'd1);
    check("to_hang_ready", 64'(cmt_ready), 64'd0);

    // Accept on the would-be hang edge wins, and the counter restarts from it.
    do_reset();
    repeat (TIMEOUT - 1) @(posedge clk);
    #1;
    do_commit(64'h8000_0200, NOP, 1'b1, 5'd1, 64'h11);
    check("to_accept_wins", 64'(hang), 64'd0);
    check("to_accept_cnt", inst_cnt, 64'd1);
    repeat (TIMEOUT - 1) @(posedge clk);
    #1;
    check("to_restart_no_hang", 64'(hang), 64'd0);
    @(posedge clk);
    #1;
    check("to_restart_hang", 64'(hang), 64'd1);

    // Asynchronous reset between edges discards a pending snapshot.
    do_reset();
    dt_ready = 1'b0;
    do_commit(64'h8000_0300, NOP, 1'b1, 5'd6, 64'h66);
    #2;
    rst = 1'b1;
    #1;
    check("arst_dt_valid", 64'(dt_valid), 64'd0);
    check("arst_pc", pc_val, 64'd0);
    check("arst_cnt", inst_cnt, 64'd0);
    check("arst_gpr_any", 64'(|gpr_flat), 64'd0);
    do_reset();

`ifdef IRINGBUF_EN
    for (int i = 0; i < 10; i++) begin
      do_commit(64'h100 + 64'(4 * i), NOP, 1'b0, 5'd0, 64'd0);
    end
    check("ring_ptr", 64'(iring_ptr), 64'd2);
    check("ring_e0", iring_flat[0*64 +: 64], 64'h120);
    check("ring_e1", iring_flat[1*64 +: 64], 64'h124);
    check("ring_e2", iring_flat[2*64 +: 64], 64'h108);
    check("ring_e7", iring_flat[7*64 +: 64], 64'h11c);
    #2;
    rst = 1'b1;
    #1;
    check("ring_arst_flat", 64'(|iring_flat), 64'd0);
    check("ring_arst_ptr", 64'(iring_ptr), 64'd0);
    check("ring_arst_pc", pc_val, 64'd0);
    do_reset();
`endif

    dt_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
